// File: rtl/st_irq_arbiter.sv
// -----------------------------------------------------------------------------
// st_irq_arbiter
//
// Interrupt arbiter for an Atari ST style system. Three interrupt sources share
// the 68000 IPL lines:
//   - MFP  (level MFP_LEVEL, default 6) : level-sensitive request
//   - VBL  (level VBL_LEVEL, default 4) : rising-edge request, latched as pending
//   - HBL  (level HBL_LEVEL, default 2) : rising-edge request, latched as pending
// The highest active request is encoded onto ipl_n. The block also sequences
// the CPU interrupt-acknowledge (IACK) bus cycle:
//   - MFP level      : forwards IACK to the MFP and waits for its dtack, which
//                      the MFP gives together with its vector
//   - VBL/HBL levels : requests an autovector through vpa_n
//   - any other level, or no MFP dtack within IACK_TIMEOUT ticks : berr_n
// All state advances only on clk_en ticks. Reset is asynchronous, active high,
// and takes effect at once regardless of clk_en.
//
// Ports
//   clk        in   1  system clock
//   reset      in   1  asynchronous, active-high reset
//   clk_en     in   1  CPU-rate enable; all state advances only when high
//   mfp_irq    in   1  MFP interrupt request, level, active high
//   hbl        in   1  HBL request, rising-edge sensitive
//   vbl        in   1  VBL request, rising-edge sensitive
//   cpu_fc     in   3  CPU function code
//   cpu_as_n   in   1  CPU address strobe, active low
//   cpu_a      in   3  CPU A3..A1 (acknowledged level during IACK)
//   mfp_dtack  in   1  MFP dtack output
//   ipl_n      out  3  encoded interrupt level to CPU, active low
//   mfp_iack   out  1  IACK strobe to the MFP
//   vpa_n      out  1  autovector request, active low
//   berr_n     out  1  bus error for spurious/timed-out IACK, active low
//   busy       out  1  high whenever the acknowledge FSM is not idle
// -----------------------------------------------------------------------------
module st_irq_arbiter #(
    parameter int IACK_TIMEOUT = 64,
    parameter int MFP_LEVEL    = 6,
    parameter int VBL_LEVEL    = 4,
    parameter int HBL_LEVEL    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic       mfp_irq,
    input  logic       hbl,
    input  logic       vbl,
    input  logic [2:0] cpu_fc,
    input  logic       cpu_as_n,
    input  logic [2:0] cpu_a,
    input  logic       mfp_dtack,
    output logic [2:0] ipl_n,
    output logic       mfp_iack,
    output logic       vpa_n,
    output logic       berr_n,
    output logic       busy
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    // The counter is wide enough to hold IACK_TIMEOUT itself, so the terminal
    // value IACK_TIMEOUT-1 is always representable and the count never wraps.
    localparam int CNT_W = $clog2(IACK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] MFP_LVL = 3'(MFP_LEVEL);
    localparam logic [2:0] VBL_LVL = 3'(VBL_LEVEL);
    localparam logic [2:0] HBL_LVL = 3'(HBL_LEVEL);

    // CPU function code for an interrupt-acknowledge (CPU space) cycle.
    localparam logic [2:0] FC_IACK = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,     // waiting for an IACK cycle; ipl_n tracks requests
        S_MFP_ACK,  // mfp_iack driven, waiting for mfp_dtack or timeout
        S_AUTO,     // vpa_n driven, waiting for the CPU to end the cycle
        S_SPUR,     // berr_n driven, waiting for the CPU to end the cycle
        S_DONE      // MFP answered; mfp_iack held so the vector stays driven
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state;
    logic [CNT_W-1:0] count;
    logic             hbl_q;
    logic             vbl_q;
    logic             hbl_pend;
    logic             vbl_pend;

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    logic       iack;        // CPU is running an interrupt-acknowledge cycle
    logic       accept;      // the IACK is taken this tick (only from idle)
    logic       lvl_is_mfp;
    logic       lvl_is_vbl;
    logic       lvl_is_hbl;
    logic       hbl_rise;
    logic       vbl_rise;
    logic       hbl_clr;
    logic       vbl_clr;
    logic [2:0] level;       // highest active request level, 0 when none

    assign iack       = (cpu_fc == FC_IACK) && !cpu_as_n;
    assign accept     = (state == S_IDLE) && iack;

    assign lvl_is_mfp = (cpu_a == MFP_LVL);
    assign lvl_is_vbl = (cpu_a == VBL_LVL);
    assign lvl_is_hbl = (cpu_a == HBL_LVL);

    // Edges are judged against the value seen on the previous clk_en tick.
    assign hbl_rise   = hbl && !hbl_q;
    assign vbl_rise   = vbl && !vbl_q;

    // A pending flag is consumed when its own autovector IACK is accepted.
    assign hbl_clr    = accept && lvl_is_hbl;
    assign vbl_clr    = accept && lvl_is_vbl;

    always_comb begin
        // NOTE: a default assignment first means every path through this block
        // assigns level, so no latch is inferred.
        level = 3'd0;
        if (mfp_irq) begin
            level = MFP_LVL;
        end else if (vbl_pend) begin
            level = VBL_LVL;
        end else if (hbl_pend) begin
            level = HBL_LVL;
        end
    end

    // -------------------------------------------------------------------------
    // Request edge detection and pending flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state is written with non-blocking assignments so
            // every register samples the pre-edge values of the others.
            hbl_q    <= 1'b0;
            vbl_q    <= 1'b0;
            hbl_pend <= 1'b0;
            vbl_pend <= 1'b0;
        end else if (clk_en) begin
            hbl_q <= hbl;
            vbl_q <= vbl;

            // Set has priority over clear: an edge arriving on the same tick as
            // its acknowledge must not be lost.
            if (hbl_rise) begin
                hbl_pend <= 1'b1;
            end else if (hbl_clr) begin
                hbl_pend <= 1'b0;
            end

            if (vbl_rise) begin
                vbl_pend <= 1'b1;
            end else if (vbl_clr) begin
                vbl_pend <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // IPL encoding
    // -------------------------------------------------------------------------
    // ipl_n is held while an acknowledge is in progress so the CPU sees a
    // stable level for the whole bus cycle; it resumes tracking in idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ipl_n <= 3'b111;
        end else if (clk_en && (state == S_IDLE)) begin
            ipl_n <= ~level;
        end
    end

    // -------------------------------------------------------------------------
    // Acknowledge sequencer with registered strobes
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= '0;
            mfp_iack <= 1'b0;
            vpa_n    <= 1'b1;
            berr_n   <= 1'b1;
            busy     <= 1'b0;
        end else if (clk_en) begin
            if ((state != S_IDLE) && cpu_as_n) begin
                // The CPU ended (or aborted) the bus cycle: release everything
                // on this tick, whatever stage the acknowledge had reached.
                state    <= S_IDLE;
                mfp_iack <= 1'b0;
                vpa_n    <= 1'b1;
                berr_n   <= 1'b1;
                busy     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (iack) begin
                            busy <= 1'b1;
                            if (lvl_is_mfp) begin
                                state    <= S_MFP_ACK;
                                mfp_iack <= 1'b1;
                                count    <= '0;
                            end else if (lvl_is_vbl || lvl_is_hbl) begin
                                // Autovector is given even if the pending flag
                                // has already gone; the CPU asked for it.
                                state <= S_AUTO;
                                vpa_n <= 1'b0;
                            end else begin
                                state  <= S_SPUR;
                                berr_n <= 1'b0;
                            end
                        end
                    end

                    S_MFP_ACK: begin
                        // mfp_irq is deliberately ignored here: once IACK has
                        // been forwarded the MFP still owns the vector.
                        if (mfp_dtack) begin
                            state <= S_DONE;
                        end else if (count == CNT_LAST) begin
                            state    <= S_SPUR;
                            mfp_iack <= 1'b0;
                            berr_n   <= 1'b0;
                        end else begin
                            count <= count + CNT_ONE;
                        end
                    end

                    // These states only wait for the address strobe to rise,
                    // which is handled above.
                    S_AUTO, S_SPUR, S_DONE: begin
                    end

                    default: begin
                        // Unreachable encodings recover to a clean idle.
                        state    <= S_IDLE;
                        mfp_iack <= 1'b0;
                        vpa_n    <= 1'b1;
                        berr_n   <= 1'b1;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_st_irq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_st_irq_arbiter
//
// Scoreboard bench for st_irq_arbiter. The driver applies inputs on the falling
// edge, advances a behavioural model of the arbiter for that clock, and queues
// the outputs the DUT must show after the next rising edge. A separate monitor
// pops one expectation per rising edge and compares it with the DUT outputs.
// The model is written in terms of "is an acknowledge in progress, for which
// level, did it fault, how long has the MFP been waited for" rather than as a
// state machine.
// -----------------------------------------------------------------------------
module tb_st_irq_arbiter;

    localparam int IACK_TIMEOUT = 64;
    localparam int MFP_LEVEL    = 6;
    localparam int VBL_LEVEL    = 4;
    localparam int HBL_LEVEL    = 2;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       clk_en    = 1'b0;
    logic       mfp_irq   = 1'b0;
    logic       hbl       = 1'b0;
    logic       vbl       = 1'b0;
    logic [2:0] cpu_fc    = 3'd0;
    logic       cpu_as_n  = 1'b1;
    logic [2:0] cpu_a     = 3'd0;
    logic       mfp_dtack = 1'b0;
    logic [2:0] ipl_n;
    logic       mfp_iack;
    logic       vpa_n;
    logic       berr_n;
    logic       busy;

    st_irq_arbiter #(
        .IACK_TIMEOUT(IACK_TIMEOUT),
        .MFP_LEVEL   (MFP_LEVEL),
        .VBL_LEVEL   (VBL_LEVEL),
        .HBL_LEVEL   (HBL_LEVEL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clk_en   (clk_en),
        .mfp_irq  (mfp_irq),
        .hbl      (hbl),
        .vbl      (vbl),
        .cpu_fc   (cpu_fc),
        .cpu_as_n (cpu_as_n),
        .cpu_a    (cpu_a),
        .mfp_dtack(mfp_dtack),
        .ipl_n    (ipl_n),
        .mfp_iack (mfp_iack),
        .vpa_n    (vpa_n),
        .berr_n   (berr_n),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ipl_n;
        logic       mfp_iack;
        logic       vpa_n;
        logic       berr_n;
        logic       busy;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    bit       m_hbl_prev, m_vbl_prev;
    bit       m_hbl_pend, m_vbl_pend;
    bit [2:0] m_ipl_n;
    bit       m_in_cycle;   // an acknowledge has been accepted and not yet ended
    int       m_lvl;        // level the CPU acknowledged
    bit       m_berr;       // this acknowledge ended in a bus error
    bit       m_vec_done;   // the MFP answered with dtack
    int       m_wait;       // ticks spent waiting for the MFP

    task automatic model_reset();
        m_hbl_prev = 0; m_vbl_prev = 0;
        m_hbl_pend = 0; m_vbl_pend = 0;
        m_ipl_n    = 3'b111;
        m_in_cycle = 0; m_lvl = 0; m_berr = 0; m_vec_done = 0; m_wait = 0;
    endtask

    function automatic int pending_level();
        if (mfp_irq)    return MFP_LEVEL;
        if (m_vbl_pend) return VBL_LEVEL;
        if (m_hbl_pend) return HBL_LEVEL;
        return 0;
    endfunction

    // One clk_en tick, using the inputs currently applied.
    task automatic model_tick();
        int lvl_now  = pending_level();
        bit iack_now = (cpu_fc == 3'd7) && !cpu_as_n;
        bit start    = !m_in_cycle && iack_now;
        int a        = int'(cpu_a);

        if (!m_in_cycle) m_ipl_n = ~3'(lvl_now);

        if (hbl && !m_hbl_prev)                m_hbl_pend = 1;
        else if (start && a == HBL_LEVEL)      m_hbl_pend = 0;
        if (vbl && !m_vbl_prev)                m_vbl_pend = 1;
        else if (start && a == VBL_LEVEL)      m_vbl_pend = 0;

        if (start) begin
            m_in_cycle = 1;
            m_lvl      = a;
            m_berr     = !(a == MFP_LEVEL || a == VBL_LEVEL || a == HBL_LEVEL);
            m_vec_done = 0;
            m_wait     = 0;
        end else if (m_in_cycle && cpu_as_n) begin
            m_in_cycle = 0;
            m_berr     = 0;
        end else if (m_in_cycle && m_lvl == MFP_LEVEL && !m_berr && !m_vec_done) begin
            if (mfp_dtack)                       m_vec_done = 1;
            else if (m_wait + 1 == IACK_TIMEOUT) m_berr = 1;
            else                                 m_wait++;
        end

        m_hbl_prev = hbl;
        m_vbl_prev = vbl;
    endtask

    function automatic obs_t model_out();
        obs_t o;
        o.ipl_n    = m_ipl_n;
        o.busy     = m_in_cycle;
        o.mfp_iack = m_in_cycle && m_lvl == MFP_LEVEL && !m_berr;
        o.vpa_n    = !(m_in_cycle && (m_lvl == HBL_LEVEL || m_lvl == VBL_LEVEL));
        o.berr_n   = !m_berr;
        return o;
    endfunction

    // -------------------------------------------------------------------------
    // Driver helpers (called at a falling edge, return at the next one)
    // -------------------------------------------------------------------------
    task automatic step(input bit en);
        clk_en = en;
        if (reset)   model_reset();
        else if (en) model_tick();
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        repeat (n) step(1'b1);
    endtask

    task automatic iack_start(input logic [2:0] a);
        cpu_fc   = 3'd7;
        cpu_a    = a;
        cpu_as_n = 1'b0;
    endtask

    task automatic bus_release();
        cpu_as_n  = 1'b1;
        cpu_fc    = 3'd0;
        mfp_dtack = 1'b0;
    endtask

    task automatic bg_rand();
        if ($urandom_range(7) == 0)  hbl     = ~hbl;
        if ($urandom_range(7) == 0)  vbl     = ~vbl;
        if ($urandom_range(15) == 0) mfp_irq = ~mfp_irq;
    endtask

    task automatic rstep();
        bg_rand();
        step($urandom_range(3) != 0);
    endtask

    // Reset asserted between edges must clear the outputs without waiting.
    task automatic async_reset_pulse();
        #2 reset = 1'b1;
        #1;
        check("async reset ipl_n",    32'(ipl_n),    32'(3'b111));
        check("async reset mfp_iack", 32'(mfp_iack), 32'(1'b0));
        check("async reset vpa_n",    32'(vpa_n),    32'(1'b1));
        check("async reset berr_n",   32'(berr_n),   32'(1'b1));
        check("async reset busy",     32'(busy),     32'(1'b0));
        step(1'b0);
        step(1'($urandom_range(1)));
        reset = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------------
    initial begin
        obs_t e;
        obs_t got;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = '{ipl_n, mfp_iack, vpa_n, berr_n, busy};
                check($sformatf("outputs{ipl_n,mfp_iack,vpa_n,berr_n,busy} cycle %0d", cyc),
                      32'(got), 32'(e));
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int len;
        int dt;

        @(negedge clk);
        step(1'b0);
        step(1'b1);
        reset = 1'b0;
        steps(3);

        // VBL pulse, then its autovector acknowledge.
        vbl = 1'b1; step(1'b1);
        vbl = 1'b0; steps(2);
        iack_start(3'd4); steps(2); step(1'b0); steps(1);
        bus_release(); steps(3);

        // MFP plus HBL; MFP acknowledge answered after three ticks.
        mfp_irq = 1'b1; hbl = 1'b1; step(1'b1);
        hbl = 1'b0; steps(2);
        iack_start(3'd6); steps(3);
        mfp_dtack = 1'b1; step(1'b1);
        mfp_dtack = 1'b0; mfp_irq = 1'b0; steps(3);
        bus_release(); steps(3);

        // MFP acknowledge that is never answered: timeout to bus error.
        iack_start(3'd6);
        for (int i = 0; i < IACK_TIMEOUT + 6; i++) step((i % 9) != 4);
        bus_release(); steps(3);

        // Consume the HBL still pending, then an HBL edge on the acknowledge tick.
        iack_start(3'd2); steps(2);
        bus_release(); steps(3);
        iack_start(3'd2); hbl = 1'b1; step(1'b1);
        steps(2); hbl = 1'b0;
        bus_release(); steps(3);

        // Async reset in the middle of an MFP acknowledge.
        mfp_irq = 1'b1; steps(2);
        iack_start(3'd6); steps(3); step(1'b0);
        async_reset_pulse();
        mfp_irq = 1'b0; bus_release(); steps(3);

        // Spurious level with nothing pending; aborted cycles of every kind.
        iack_start(3'd3); steps(3);
        bus_release(); steps(2);
        iack_start(3'd6); steps(2); bus_release(); steps(2);
        iack_start(3'd0); steps(1); bus_release(); steps(2);
        iack_start(3'd7); steps(2); bus_release(); steps(2);

        // Randomised bus traffic.
        for (int c = 0; c < 220; c++) begin
            bus_release();
            cpu_fc = 3'($urandom);
            repeat ($urandom_range(1, 6)) rstep();
            if ($urandom_range(39) == 0) async_reset_pulse();
            cpu_fc = ($urandom_range(3) == 0) ? 3'($urandom) : 3'd7;
            case ($urandom_range(3))
                0:       cpu_a = 3'd2;
                1:       cpu_a = 3'd4;
                2:       cpu_a = 3'd6;
                default: cpu_a = 3'($urandom);
            endcase
            cpu_as_n = 1'b0;
            if ($urandom_range(15) == 0) begin
                len = IACK_TIMEOUT + 20;
                dt  = len;
            end else begin
                len = $urandom_range(1, 12);
                dt  = $urandom_range(0, 10);
            end
            for (int t = 0; t < len; t++) begin
                mfp_dtack = (t >= dt) && ($urandom_range(3) != 0);
                rstep();
            end
        end

        bus_release();
        steps(4);
        clk_en = 1'b0;
        @(posedge clk);
        #2;
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
